// File: rtl/pattern_shift_engine.sv
// Pattern register stepped by a prescaled tick through shift/rotate/bounce modes.
// Load and stepped values show on out one cycle after their edge; no backpressure.
module pattern_shift_engine #(
    parameter int               WIDTH     = 8,
    parameter int               DIV_WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT      = WIDTH'(1)
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     data,
    input  logic                 en,
    input  logic [2:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [WIDTH-1:0]     out,
    output logic                 dir,
    output logic                 step,
    output logic                 wrap
);

    localparam int M = WIDTH - 1;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_ROL    = 3'd1,
        MODE_ROR    = 3'd2,
        MODE_SLL    = 3'd3,
        MODE_SRL    = 3'd4,
        MODE_SRA    = 3'd5,
        MODE_BOUNCE = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_e;

    logic [DIV_WIDTH-1:0] cnt;
    logic                 tick;
    logic [WIDTH-1:0]     nxt_out;
    logic                 nxt_dir;
    logic                 nxt_wrap;

    // >= rather than == so that shrinking div mid-count never strands the counter
    assign tick = en && (cnt >= div);

    always_comb begin
        nxt_out  = out;
        nxt_dir  = dir;
        nxt_wrap = 1'b0;
        case (mode_e'(mode))
            MODE_ROL: begin
                nxt_out  = {out[M-1:0], out[M]};
                nxt_wrap = out[M];
            end
            MODE_ROR: begin
                nxt_out  = {out[0], out[M:1]};
                nxt_wrap = out[0];
            end
            MODE_SLL: begin
                nxt_out  = {out[M-1:0], 1'b0};
                nxt_wrap = out[M];
            end
            MODE_SRL: begin
                nxt_out  = {1'b0, out[M:1]};
                nxt_wrap = out[0];
            end
            MODE_SRA: begin
                nxt_out  = {out[M], out[M:1]};
                nxt_wrap = out[0];
            end
            MODE_BOUNCE: begin
                if (out != '0) begin
                    if (!dir) begin
                        if (out[M]) begin
                            nxt_dir  = 1'b1;
                            nxt_out  = {1'b0, out[M:1]};
                            nxt_wrap = 1'b1;
                        end else begin
                            nxt_out = {out[M-1:0], 1'b0};
                        end
                    end else begin
                        if (out[0]) begin
                            nxt_dir  = 1'b0;
                            nxt_out  = {out[M-1:0], 1'b0};
                            nxt_wrap = 1'b1;
                        end else begin
                            nxt_out = {1'b0, out[M:1]};
                        end
                    end
                end
            end
            MODE_HOLD, MODE_RSVD: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out  <= INIT;
            dir  <= 1'b0;
            cnt  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            out  <= data;
            dir  <= 1'b0;
            cnt  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (tick) begin
            out  <= nxt_out;
            dir  <= nxt_dir;
            cnt  <= '0;
            step <= 1'b1;
            wrap <= nxt_wrap;
        end else begin
            if (en) begin
                cnt <= cnt + 1'b1;
            end
            step <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pattern_shift_engine.sv
// Directed and random stimulus against an arithmetic reference model of the pattern engine.
module tb_pattern_shift_engine;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        load;
    logic [7:0]  data;
    logic        en;
    logic [2:0]  mode;
    logic [15:0] div;
    logic [7:0]  out;
    logic        dir;
    logic        step;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    // reference state, plain integers
    int m_out, m_dir, m_cnt, m_step, m_wrap;

    pattern_shift_engine #(
        .WIDTH(8),
        .DIV_WIDTH(16),
        .INIT(8'h01)
    ) dut (
        .clk(clk),
        .clear_n(clear_n),
        .load(load),
        .data(data),
        .en(en),
        .mode(mode),
        .div(div),
        .out(out),
        .dir(dir),
        .step(step),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 1; m_dir = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
    endtask

    task automatic model_apply_mode();
        int v;
        v = m_out;
        m_wrap = 0;
        case (int'(mode))
            1: begin m_wrap = v / 128; m_out = (v * 2) % 256 + v / 128; end
            2: begin m_wrap = v % 2;   m_out = v / 2 + (v % 2) * 128; end
            3: begin m_wrap = v / 128; m_out = (v * 2) % 256; end
            4: begin m_wrap = v % 2;   m_out = v / 2; end
            5: begin m_wrap = v % 2;   m_out = v / 2 + ((v >= 128) ? 128 : 0); end
            6: begin
                if (v != 0) begin
                    if (m_dir == 0) begin
                        if (v >= 128) begin m_dir = 1; m_out = v / 2; m_wrap = 1; end
                        else m_out = v * 2;
                    end else begin
                        if (v % 2 == 1) begin m_dir = 0; m_out = (v * 2) % 256; m_wrap = 1; end
                        else m_out = v / 2;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        if (!clear_n) model_reset();
        else if (load) begin
            m_out = int'(data); m_dir = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
        end else if (en && m_cnt >= int'(div)) begin
            model_apply_mode();
            m_cnt = 0; m_step = 1;
        end else begin
            if (en) m_cnt++;
            m_step = 0; m_wrap = 0;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".out"},  32'(out),  32'(m_out));
        check({tag, ".dir"},  32'(dir),  32'(m_dir));
        check({tag, ".step"}, 32'(step), 32'(m_step));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    task automatic do_load(input logic [7:0] val);
        load = 1'b1; data = val;
        cyc("load");
        load = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; load = 1'b0; data = 8'h00; en = 1'b1; mode = 3'd1; div = 16'd0;
        model_reset();

        // reset with en and rotate selected
        cyc("rst");
        cyc("rst");
        check("rst.out_const", 32'(out), 32'h01);
        check("rst.step_const", 32'(step), 32'h0);

        clear_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle");
        check("idle.out_const", 32'(out), 32'h01);

        // rotate left, one step per cycle
        en = 1'b1; mode = 3'd1; div = 16'd0;
        for (int i = 0; i < 7; i++) cyc("rol");
        check("rol.at80", 32'(out), 32'h80);
        check("rol.at80_wrap", 32'(wrap), 32'h0);
        cyc("rol");
        check("rol.back01", 32'(out), 32'h01);
        check("rol.back01_wrap", 32'(wrap), 32'h1);

        // prescaled rotate right
        do_load(8'h01);
        mode = 3'd2; div = 16'd3;
        for (int i = 0; i < 3; i++) cyc("pre");
        check("pre.nostep", 32'(step), 32'h0);
        cyc("pre");
        check("pre.first_out", 32'(out), 32'h80);
        check("pre.first_wrap", 32'(wrap), 32'h1);
        for (int i = 0; i < 8; i++) cyc("pre");
        div = 16'd6;
        for (int i = 0; i < 3; i++) cyc("pre_div6");
        div = 16'd1;
        cyc("pre_drop");
        check("pre.drop_tick", 32'(step), 32'h1);

        // bounce across the full width and back
        div = 16'd0;
        do_load(8'h01);
        mode = 3'd6;
        for (int i = 0; i < 7; i++) cyc("bnc");
        check("bnc.at80", 32'(out), 32'h80);
        cyc("bnc");
        check("bnc.rev_out", 32'(out), 32'h40);
        check("bnc.rev_dir", 32'(dir), 32'h1);
        check("bnc.rev_wrap", 32'(wrap), 32'h1);
        for (int i = 0; i < 6; i++) cyc("bnc");
        check("bnc.at01", 32'(out), 32'h01);
        cyc("bnc");
        check("bnc.ret_out", 32'(out), 32'h02);
        check("bnc.ret_dir", 32'(dir), 32'h0);
        do_load(8'h00);
        cyc("bnc0");
        cyc("bnc0");
        check("bnc0.out", 32'(out), 32'h00);
        check("bnc0.step", 32'(step), 32'h1);

        // arithmetic and logical shifts
        do_load(8'h81);
        mode = 3'd5;
        cyc("sra");
        check("sra.c0", 32'(out), 32'hC0);
        check("sra.c0_wrap", 32'(wrap), 32'h1);
        cyc("sra");
        check("sra.e0", 32'(out), 32'hE0);
        check("sra.e0_wrap", 32'(wrap), 32'h0);
        do_load(8'h81);
        mode = 3'd3;
        cyc("sll");
        check("sll.02", 32'(out), 32'h02);
        check("sll.wrap", 32'(wrap), 32'h1);
        mode = 3'd4;
        for (int i = 0; i < 3; i++) cyc("srl");
        mode = 3'd7;
        for (int i = 0; i < 2; i++) cyc("rsvd");
        mode = 3'd0;
        cyc("hold");

        // load beats a due tick and restarts the prescaler
        mode = 3'd1; div = 16'd2;
        cyc("pri");
        cyc("pri");
        do_load(8'h55);
        check("pri.out", 32'(out), 32'h55);
        check("pri.step", 32'(step), 32'h0);
        for (int i = 0; i < 3; i++) cyc("pri_after");
        check("pri.restart_tick", 32'(step), 32'h1);

        // asynchronous reset while bouncing toward LSB
        div = 16'd0;
        do_load(8'h01);
        mode = 3'd6;
        for (int i = 0; i < 8; i++) cyc("abnc");
        check("async.pre_dir", 32'(dir), 32'h1);
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        check("async.out", 32'(out), 32'h01);
        check("async.dir", 32'(dir), 32'h0);
        cyc("async_hold");
        clear_n = 1'b1;
        div = 16'd2;
        for (int i = 0; i < 3; i++) cyc("async_rel");
        check("async.first_tick", 32'(step), 32'h1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            clear_n = ($urandom % 64) != 0;
            load    = ($urandom % 12) == 0;
            data    = 8'($urandom);
            en      = ($urandom % 4) != 0;
            mode    = 3'($urandom);
            div     = 16'($urandom % 4);
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
